mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-cycle multiply/divide unit with architectural HI/LO registers for the MIPS execute stage. It sits beside the ALU, takes the same rs/rt operands (In1/In2), and runs MULT, MULTU, DIV and DIVU. Its HI/LO values feed the EX result mux for MFHI/MFLO. `busy` drives the hazard unit's stall for any HI/LO access while an operation is in flight.

## Interface
Parameters:
- none; width fixed at 32 (HI/LO 32 each).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  launch op; accepted only when busy=0.
- op  in  2  operation: MULT, MULTU, DIV, DIVU.
- In1  in  32  rs: multiplicand / dividend / MTHI-MTLO data.
- In2  in  32  rt: multiplier / divisor.
- mthi  in  1  write In1 to HI (idle only).
- mtlo  in  1  write In1 to LO (idle only).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by an op.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- Op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- FSM states and transitions:
  - IDLE: start → CALC, counter = 0. The edge with start captures op, In1, In2, the operand signs and the magnitudes. Magnitudes are absolute values for signed ops and raw values for unsigned ops. Operands may change after that edge.
  - CALC: one radix-2 step per cycle; counter 0..31; after step 31 → FIX.
  - FIX: sign correction; write HI/LO; done=1; → IDLE.
- Multiply:
  - Shift-add on magnitudes into a 64-bit accumulator.
  - Signed result is negated if sign(In1)^sign(In2).
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring unsigned division on magnitudes.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - 0x80000000 / -1 (signed) gives LO=0x80000000, HI=0.
  - Divisor 0, DIV or DIVU: LO=0xFFFFFFFF, HI=In1 as captured. Takes the same latency, with no early exit.
- Contention rules:
  - start while busy: ignored.
  - mthi/mtlo while busy: ignored.
  - In IDLE, start has priority over mthi/mtlo in the same cycle; the mthi/mtlo is dropped.
  - mthi and mtlo together when idle: both written.
- Reset:
  - hi=0, lo=0, busy=0, done=0, state IDLE.
  - Reset mid-operation aborts the op: no done pulse, and HI/LO hold the reset value.

## Timing
- Edge E0: start accepted. From E0, busy=1 and state is CALC.
- Edges E1..E32: the 32 iteration steps. State is FIX after E32.
- Edge E33: hi/lo updated, done=1 for exactly one cycle, busy=0.
- busy is high for exactly 33 cycles. A new start is accepted at E34, or at E33 only if it is sampled when busy=0 (i.e. not at E33).
- mthi/mtlo: hi/lo change on the edge that samples them; 1-cycle latency; no done pulse.
- hi/lo are registered outputs. They hold their previous values throughout CALC; no partial results are visible.
- done and busy are registered with no combinational path from inputs.

## Structure
- `muldiv_opcodes.vh`, shared header alongside the ALU opcode header, holds:
  - the op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state encodings IDLE, CALC, FIX;
  - the iteration count constant 32.
- One sub-module is natural: `muldiv_step`, a combinational single-iteration step.
  - Mode multiply: conditional add and shift.
  - Mode divide: trial subtract and shift.
  - Instantiated once in the top-level FSM/datapath.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done exactly 33 edges after start; busy high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5 after 33 cycles. DIV 0xFFFFFFF9 / 0 → LO=0xFFFFFFFF, HI=0xFFFFFFF9.
- During a busy MULT:
  - a second start (DIVU 9/3) is ignored, and the original result is produced;
  - mthi with In1=0x1234 is ignored, and HI equals the product.
- Reset and idle writes:
  - rst pulsed at cycle 10 of a DIV → hi=lo=0, busy=0, no done pulse.
  - Afterwards, mtlo with In1=0x1234 gives lo=0x1234 next cycle, hi unchanged.
  - start+mthi in the same idle cycle → op runs, HI not written from In1.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit:
// op encodings, FSM state encoding and iteration count.
package mul_div_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int         ITER_COUNT = 32;
  localparam logic [4:0] LAST_STEP  = 5'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on a 64-bit accumulator: shift-add for multiply,
// restoring trial-subtract for divide. Purely combinational.
module muldiv_step (
  input  logic        mode_div,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] diff;

  // Remainder plus the next dividend bit can reach 33 bits, so the trial
  // subtract runs at 33 bits and its borrow decides the quotient bit.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, operand};
    diff     = acc[63:31] - {1'b0, operand};
    acc_next = acc;
    if (mode_div) begin
      if (!diff[32])
        acc_next = {diff[31:0], acc[30:0], 1'b1};
      else
        acc_next = {acc[62:0], 1'b0};
    end else begin
      if (acc[0])
        acc_next = {sum, acc[31:1]};
      else
        acc_next = {1'b0, acc[63:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-step multiply/divide unit holding the architectural HI/LO
// registers; busy stalls HI/LO consumers while an op is in flight.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_reg, state_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [4:0]  count_reg;
  logic        div_mode_reg;
  logic        neg_res_reg;
  logic        neg_rem_reg;
  logic        div_zero_reg;
  logic [31:0] in1_reg;
  logic [31:0] opnd_reg;
  logic [63:0] acc_reg;
  logic [63:0] acc_next;
  logic [31:0] hi_reg, lo_reg;

  logic        signed_op;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod_fix;
  logic [31:0] hi_fix, lo_fix;

  muldiv_step u_step (
    .mode_div (div_mode_reg),
    .acc      (acc_reg),
    .operand  (opnd_reg),
    .acc_next (acc_next)
  );

  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    mag_a     = (signed_op && In1[31]) ? -In1 : In1;
    mag_b     = (signed_op && In2[31]) ? -In2 : In2;
  end

  // State register, plus busy/done registered from the FSM decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count_reg == LAST_STEP) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = (state_reg == FIX);
  end

  // Sign correction; divide-by-zero bypasses the iterative result entirely
  always_comb begin
    prod_fix = neg_res_reg ? -acc_reg : acc_reg;
    hi_fix   = prod_fix[63:32];
    lo_fix   = prod_fix[31:0];
    if (div_mode_reg) begin
      if (div_zero_reg) begin
        hi_fix = in1_reg;
        lo_fix = 32'hFFFF_FFFF;
      end else begin
        hi_fix = neg_rem_reg ? -acc_reg[63:32] : acc_reg[63:32];
        lo_fix = neg_res_reg ? -acc_reg[31:0]  : acc_reg[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      div_mode_reg <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      in1_reg      <= '0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            count_reg    <= '0;
            div_mode_reg <= op[1];
            neg_res_reg  <= signed_op & (In1[31] ^ In2[31]);
            neg_rem_reg  <= signed_op & In1[31];
            div_zero_reg <= (In2 == 32'd0);
            in1_reg      <= In1;
            if (op[1]) begin
              acc_reg  <= {32'd0, mag_a};
              opnd_reg <= mag_b;
            end else begin
              acc_reg  <= {32'd0, mag_b};
              opnd_reg <= mag_a;
            end
          end else begin
            if (mthi) hi_reg <= In1;
            if (mtlo) lo_reg <= In1;
          end
        end
        CALC: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg + 5'd1;
        end
        FIX: begin
          hi_reg <= hi_fix;
          lo_reg <= lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latency,
// contention and reset-abort behaviour.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run  = 0;
  int tests_fail = 0;
  int lat_cnt;
  int busy_cnt;
  int done_seen;
  logic [31:0] hi_prev;

  mul_div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .In1   (In1),
    .In2   (In2),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Launch an op, scramble operands after capture, then count edges to done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; In1 = a; In2 = b;
    @(posedge clk); #1;
    start = 1'b0; In1 = $urandom; In2 = $urandom;
    lat_cnt  = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat_cnt++;
      if (done) break;
      if (busy) busy_cnt++;
    end
    if (!done) lat_cnt = -1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; In1 = '0; In2 = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_latency", lat_cnt, 32'd33);
    check("multu_busy_cycles", busy_cnt, 32'd33);
    check("multu_busy_at_done", {31'd0, busy}, 32'd0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    check("mult_min_hi", hi, 32'h4000_0000);
    check("mult_min_lo", lo, 32'h0);

    do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    do_op(2'b11, 32'd100, 32'd7);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);
    do_op(2'b11, 32'd5, 32'd0);
    check("divu0_latency", lat_cnt, 32'd33);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd5);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFF9);

    // Contention during a busy MULTU 6 x 7
    hi_prev = hi;
    @(negedge clk);
    start = 1'b1; op = 2'b01; In1 = 32'd6; In2 = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'b11; In1 = 32'd9; In2 = 32'd3;
    @(negedge clk); start = 1'b0;
    mthi = 1'b1; In1 = 32'h1234;
    @(negedge clk); mthi = 1'b0;
    check("hold_hi_in_calc", hi, hi_prev);
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) begin done_seen = 1; break; end
    end
    check("contend_done_seen", done_seen, 32'd1);
    check("contend_hi", hi, 32'd0);
    check("contend_lo", lo, 32'd42);
    @(posedge clk); #1;
    check("contend_no_restart", {31'd0, busy}, 32'd0);

    // Reset ten cycles into a DIV
    @(negedge clk);
    start = 1'b1; op = 2'b10; In1 = 32'hFFFF_FFF9; In2 = 32'd2;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1;
    end
    check("abort_no_done", done_seen, 32'd0);

    @(negedge clk);
    mtlo = 1'b1; In1 = 32'h1234;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_hi_unchanged", hi, 32'h0);
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; In1 = 32'hABCD;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("both_hi", hi, 32'hABCD);
    check("both_lo", lo, 32'hABCD);

    // start and mthi in the same idle cycle: start wins
    @(negedge clk);
    start = 1'b1; mthi = 1'b1; op = 2'b01; In1 = 32'd2; In2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("start_prio_hi", hi, 32'hABCD);
    check("start_prio_busy", {31'd0, busy}, 32'd1);
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) begin done_seen = 1; break; end
    end
    check("start_prio_done", done_seen, 32'd1);
    check("start_prio_res_hi", hi, 32'd0);
    check("start_prio_res_lo", lo, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
